// File: rtl/pixel_pkg.sv
// Shared constants and types for the pixel sink: screen geometry, field widths,
// the pixel record carried through the FIFO, and the sink's state encoding.
package pixel_pkg;

    localparam int H_RES   = 640;
    localparam int V_RES   = 480;
    localparam int COLOR_W = 3;
    localparam int X_W     = 10;
    localparam int Y_W     = 9;
    localparam int ADDR_W  = 19;

    typedef struct packed {
        logic [X_W-1:0]     x;
        logic [Y_W-1:0]     y;
        logic [COLOR_W-1:0] color;
    } pixel_t;

    typedef enum logic [1:0] {
        S_RUN,
        S_FLUSH,
        S_CLEAR,
        S_DONE
    } state_t;

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous circular-buffer FIFO with an explicit occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module pixel_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign data_o  = mem_q[rd_ptr_q];

    // NOTE: sequential state is always updated with <= so every register samples
    // pre-edge values, independent of the order the always blocks are evaluated.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: the storage array is deliberately left out of reset; the pointers
    // and count define which entries are valid, so stale data is never read.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/pixel_sink.sv
// Consumer end of the line-drawer pixel stream: clips, buffers and drains pixels
// into the framebuffer write port, and performs full-screen clears on request.
module pixel_sink #(
    parameter int H_RES   = pixel_pkg::H_RES,
    parameter int V_RES   = pixel_pkg::V_RES,
    parameter int COLOR_W = pixel_pkg::COLOR_W,
    parameter int DEPTH   = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [pixel_pkg::X_W-1:0]    in_x,
    input  logic [pixel_pkg::Y_W-1:0]    in_y,
    input  logic [COLOR_W-1:0]           in_color,
    input  logic                         clear_req,
    input  logic [COLOR_W-1:0]           clear_color,
    output logic                         clear_done,
    input  logic                         fb_grant,
    output logic                         fb_we,
    output logic [pixel_pkg::ADDR_W-1:0] fb_addr,
    output logic [COLOR_W-1:0]           fb_data,
    output logic                         busy,
    output logic [15:0]                  drop_count
);

    import pixel_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);

    state_t              state_q;
    logic                fb_we_q;
    logic [ADDR_W-1:0]   fb_addr_q;
    logic [COLOR_W-1:0]  fb_data_q;
    logic                clear_done_q;
    logic [15:0]         drop_q;
    logic [ADDR_W-1:0]   sweep_q;
    logic [COLOR_W-1:0]  clear_color_q;

    pixel_t              push_pix;
    pixel_t              head_pix;
    logic                fifo_full;
    logic                fifo_empty;
    logic                transfer;
    logic                clipped;
    logic                push;
    logic                pop;
    logic [ADDR_W-1:0]   head_addr;

    // A pop in the same cycle does not open in_ready when the FIFO is full.
    assign in_ready = !reset && (state_q == S_RUN) && !fifo_full && !clear_req;
    assign transfer = in_valid && in_ready;
    assign clipped  = (int'(in_x) >= H_RES) || (int'(in_y) >= V_RES);
    assign push     = transfer && !clipped;
    assign pop      = fb_grant && !fifo_empty &&
                      ((state_q == S_RUN) || (state_q == S_FLUSH));

    assign push_pix  = '{x: in_x, y: in_y, color: in_color};
    assign head_addr = ADDR_W'(head_pix.y) * ADDR_W'(H_RES) + ADDR_W'(head_pix.x);

    pixel_fifo #(
        .WIDTH ($bits(pixel_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (push_pix),
        .data_o  (head_pix),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_RUN;
            fb_we_q       <= 1'b0;
            fb_addr_q     <= '0;
            fb_data_q     <= '0;
            clear_done_q  <= 1'b0;
            drop_q        <= '0;
            sweep_q       <= '0;
            clear_color_q <= '0;
        end else begin
            fb_we_q      <= 1'b0;
            clear_done_q <= 1'b0;

            if (transfer && clipped && (drop_q != 16'hFFFF)) begin
                drop_q <= drop_q + 16'd1;
            end

            if (pop) begin
                fb_we_q   <= 1'b1;
                fb_addr_q <= head_addr;
                fb_data_q <= head_pix.color;
            end

            case (state_q)
                S_RUN: begin
                    if (clear_req) begin
                        clear_color_q <= clear_color;
                        state_q       <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    // Wait for the last queued pixel write to leave the port.
                    if (fifo_empty && !fb_we_q) begin
                        sweep_q <= '0;
                        state_q <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    if (fb_grant) begin
                        fb_we_q   <= 1'b1;
                        fb_addr_q <= sweep_q;
                        fb_data_q <= clear_color_q;
                        if (sweep_q == LAST_ADDR) begin
                            clear_done_q <= 1'b1;
                            state_q      <= S_DONE;
                        end else begin
                            sweep_q <= sweep_q + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_RUN;
                end
                default: begin
                    state_q <= S_RUN;
                end
            endcase
        end
    end

    assign fb_we      = fb_we_q;
    assign fb_addr    = fb_addr_q;
    assign fb_data    = fb_data_q;
    assign clear_done = clear_done_q;
    assign drop_count = drop_q;
    assign busy       = !fifo_empty || fb_we_q || (state_q != S_RUN);

endmodule

// File: tb/tb_pixel_sink.sv
// Self-checking bench for pixel_sink on a reduced 40x30 screen so full clears stay short.
module tb_pixel_sink;

    localparam int TH   = 40;
    localparam int TV   = 30;
    localparam int NPIX = TH * TV;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [9:0]  in_x = '0;
    logic [8:0]  in_y = '0;
    logic [2:0]  in_color = '0;
    logic        clear_req = 1'b0;
    logic [2:0]  clear_color = '0;
    logic        clear_done;
    logic        fb_grant = 1'b0;
    logic        fb_we;
    logic [18:0] fb_addr;
    logic [2:0]  fb_data;
    logic        busy;
    logic [15:0] drop_count;

    typedef struct {
        logic [18:0] addr;
        logic [2:0]  color;
    } exp_t;

    typedef struct {
        logic [9:0]  x;
        logic [8:0]  y;
        logic [2:0]  c;
        logic        clip;
        logic [18:0] addr;
    } vec_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   wr_count = 0;
    int   done_count = 0;
    int   exp_drops = 0;
    logic toggle_stop = 1'b0;

    pixel_sink #(
        .H_RES   (TH),
        .V_RES   (TV),
        .COLOR_W (3),
        .DEPTH   (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_x        (in_x),
        .in_y        (in_y),
        .in_color    (in_color),
        .clear_req   (clear_req),
        .clear_color (clear_color),
        .clear_done  (clear_done),
        .fb_grant    (fb_grant),
        .fb_we       (fb_we),
        .fb_addr     (fb_addr),
        .fb_data     (fb_data),
        .busy        (busy),
        .drop_count  (drop_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [18:0] addr_of(input int x, input int y);
        return 19'(y * TH + x);
    endfunction

    // Scoreboard: every framebuffer write must match the oldest expected entry.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && clear_done) done_count++;
        if (!reset && fb_we) begin
            wr_count++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL write_unexpected: got write to addr %0d, expected none", fb_addr);
            end else begin
                e = exp_q.pop_front();
                check("write_addr", 32'(fb_addr), 32'(e.addr));
                check("write_data", 32'(fb_data), 32'(e.color));
            end
        end
    end

    // Called just after a rising edge; returns just after the transfer edge.
    task automatic send_pixel(input logic [9:0] x, input logic [8:0] y, input logic [2:0] c,
                              input logic clip, input logic [18:0] addr);
        int waited = 0;
        exp_t e;
        in_x = x;
        in_y = y;
        in_color = c;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        check("send_ready", 32'(in_ready), 32'd1);
        if (in_ready) begin
            if (clip) begin
                exp_drops++;
            end else begin
                e.addr = addr;
                e.color = c;
                exp_q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        @(negedge clk);
        while ((busy || exp_q.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({name, "_busy"}, 32'(busy), 32'd0);
        check({name, "_queue"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic start_clear(input logic [2:0] c);
        exp_t e;
        @(posedge clk);
        #1;
        clear_req = 1'b1;
        clear_color = c;
        @(negedge clk);
        check("ready_during_clear_req", 32'(in_ready), 32'd0);
        for (int i = 0; i < NPIX; i++) begin
            e.addr = 19'(i);
            e.color = c;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        clear_req = 1'b0;
        clear_color = 3'd0;
    endtask

    task automatic run_clear(input string name, input int budget);
        int viol = 0;
        int n = 0;
        int d0 = done_count;
        logic seen = 1'b0;
        while (!seen && n < budget) begin
            @(negedge clk);
            n++;
            if (in_ready) viol++;
            if (clear_done) seen = 1'b1;
        end
        check({name, "_done_seen"}, 32'(seen), 32'd1);
        check({name, "_ready_low"}, 32'(viol), 32'd0);
        @(negedge clk);
        check({name, "_ready_after"}, 32'(in_ready), 32'd1);
        repeat (3) @(negedge clk);
        check({name, "_done_pulses"}, 32'(done_count - d0), 32'd1);
        check({name, "_all_written"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        vec_t vecs[10];
        int   w0;
        int   d0;
        int   n;

        vecs[0] = '{10'd0,    9'd0,   3'd1, 1'b0, 19'd0};
        vecs[1] = '{10'd39,   9'd0,   3'd2, 1'b0, 19'd39};
        vecs[2] = '{10'd0,    9'd1,   3'd3, 1'b0, 19'd40};
        vecs[3] = '{10'd40,   9'd0,   3'd3, 1'b1, 19'd0};
        vecs[4] = '{10'd0,    9'd30,  3'd4, 1'b1, 19'd0};
        vecs[5] = '{10'd39,   9'd29,  3'd7, 1'b0, 19'd1199};
        vecs[6] = '{10'd1023, 9'd511, 3'd7, 1'b1, 19'd0};
        vecs[7] = '{10'd12,   9'd17,  3'd6, 1'b0, 19'd692};
        vecs[8] = '{10'd20,   9'd29,  3'd4, 1'b0, 19'd1180};
        vecs[9] = '{10'd5,    9'd3,   3'd0, 1'b0, 19'd125};

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_fb_we", 32'(fb_we), 32'd0);
        check("rst_fb_addr", 32'(fb_addr), 32'd0);
        check("rst_fb_data", 32'(fb_data), 32'd0);
        check("rst_clear_done", 32'(clear_done), 32'd0);
        check("rst_drop_count", 32'(drop_count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_reset", 32'(in_ready), 32'd1);

        // Single pixel latency.
        @(posedge clk);
        #1;
        fb_grant = 1'b1;
        send_pixel(10'd5, 9'd3, 3'b101, 1'b0, addr_of(5, 3));
        @(negedge clk);
        check("single_we_n1", 32'(fb_we), 32'd0);
        check("single_busy_n1", 32'(busy), 32'd1);
        @(negedge clk);
        check("single_we_n2", 32'(fb_we), 32'd1);
        check("single_addr", 32'(fb_addr), 32'd125);
        check("single_data", 32'(fb_data), 32'd5);
        @(negedge clk);
        check("single_we_n3", 32'(fb_we), 32'd0);
        check("single_busy_n3", 32'(busy), 32'd0);

        // Table-driven pixels including clipped ones and the corner pixel.
        w0 = wr_count;
        @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) begin
            send_pixel(vecs[i].x, vecs[i].y, vecs[i].c, vecs[i].clip, vecs[i].addr);
        end
        wait_idle("table");
        check("table_drops", 32'(drop_count), 32'(exp_drops));
        check("table_writes", 32'(wr_count - w0), 32'd7);

        // Backpressure: eight fill the FIFO, the ninth waits for a pop.
        w0 = wr_count;
        @(posedge clk);
        #1;
        fb_grant = 1'b0;
        for (int i = 0; i < 8; i++) begin
            send_pixel(10'(i + 1), 9'd2, 3'(i), 1'b0, addr_of(i + 1, 2));
        end
        fork
            send_pixel(10'd30, 9'd29, 3'd7, 1'b0, addr_of(30, 29));
            begin
                repeat (3) @(negedge clk);
                check("full_ready_low", 32'(in_ready), 32'd0);
                check("full_busy", 32'(busy), 32'd1);
                check("stall_no_write", 32'(fb_we), 32'd0);
                @(posedge clk);
                #1;
                fb_grant = 1'b1;
                @(posedge clk);
                for (int i = 0; i < 9; i++) begin
                    @(negedge clk);
                    check("burst_we", 32'(fb_we), 32'd1);
                end
            end
        join
        wait_idle("burst");
        check("burst_writes", 32'(wr_count - w0), 32'd9);

        // Clear with three pixels still queued ahead of it.
        w0 = wr_count;
        @(posedge clk);
        #1;
        fb_grant = 1'b0;
        send_pixel(10'd1, 9'd1, 3'd2, 1'b0, addr_of(1, 1));
        send_pixel(10'd2, 9'd2, 3'd4, 1'b0, addr_of(2, 2));
        send_pixel(10'd3, 9'd3, 3'd6, 1'b0, addr_of(3, 3));
        start_clear(3'd0);
        fb_grant = 1'b1;
        run_clear("clear", NPIX + 100);
        check("clear_writes", 32'(wr_count - w0), 32'(NPIX + 3));

        // Clear with grant toggling every cycle.
        w0 = wr_count;
        start_clear(3'd6);
        fork
            begin
                run_clear("toggle", 2 * NPIX + 100);
                toggle_stop = 1'b1;
            end
            begin
                while (!toggle_stop) begin
                    @(posedge clk);
                    #1;
                    fb_grant = ~fb_grant;
                end
            end
        join
        check("toggle_writes", 32'(wr_count - w0), 32'(NPIX));

        // Reset in the middle of a clear sweep.
        @(posedge clk);
        #1;
        fb_grant = 1'b1;
        start_clear(3'd3);
        n = 0;
        while (!(fb_we && fb_addr == 19'd999) && n < NPIX + 100) begin
            @(negedge clk);
            n++;
        end
        check("sweep_reached_999", 32'(fb_addr), 32'd999);
        #1;
        reset = 1'b1;
        exp_q.delete();
        exp_drops = 0;
        d0 = done_count;
        @(negedge clk);
        check("midclr_fb_we", 32'(fb_we), 32'd0);
        check("midclr_busy", 32'(busy), 32'd0);
        check("midclr_drops", 32'(drop_count), 32'd0);
        check("midclr_done", 32'(clear_done), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("midclr_ready", 32'(in_ready), 32'd1);
        repeat (5) @(negedge clk);
        check("midclr_no_done", 32'(done_count - d0), 32'd0);

        // Reset with pixels waiting discards them.
        @(posedge clk);
        #1;
        fb_grant = 1'b0;
        send_pixel(10'd7, 9'd7, 3'd1, 1'b0, addr_of(7, 7));
        send_pixel(10'd8, 9'd8, 3'd2, 1'b0, addr_of(8, 8));
        send_pixel(10'd9, 9'd9, 3'd3, 1'b0, addr_of(9, 9));
        reset = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        fb_grant = 1'b1;
        w0 = wr_count;
        repeat (10) @(negedge clk);
        check("drain_reset_no_write", 32'(wr_count - w0), 32'd0);
        check("drain_reset_busy", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
